// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART encodings (TX states, parity, line levels)    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_if.sv
// +----------------------------------------------------------------------+
// | uart_tx_frame_if : host-side request bus and serial outputs of TX    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_tx_frame_if #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
);
    logic [DWIDTH-1:0] tx_data_in;
    logic              tx_data_valid;
    logic              par_en;
    logic              par_typ;
    logic [PWIDTH-1:0] prescale;
    logic              tx_out;
    logic              busy;

    modport master (
        output tx_data_in, tx_data_valid, par_en, par_typ, prescale,
        input  tx_out, busy
    );

    modport slave (
        input  tx_data_in, tx_data_valid, par_en, par_typ, prescale,
        output tx_out, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
// +----------------------------------------------------------------------+
// | uart_tx_bit_timer : counts clk cycles per serial bit, pulses done    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_bit_timer #(
    parameter int PWIDTH = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en,
    input  wire logic [PWIDTH-1:0] prescale,
    output logic                   bit_done
);

    logic [PWIDTH-1:0] r_cnt;

    // prescale is already forced to >= 1 by the framer, so P-1 never underflows
    assign bit_done = en && (r_cnt == (prescale - PWIDTH'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PWIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// +----------------------------------------------------------------------+
// | uart_tx_frame : UART transmit framer (start, data LSB-first, parity, |
// |                 stop), each bit held for prescale clk cycles         |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_frame #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_frame_if.slave  bus
);
    import uart_pkg::*;

    localparam int              IW       = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(DWIDTH - 1);

    tx_state_t          r_state;
    logic [DWIDTH-1:0]  r_data;
    logic               r_par_en;
    logic               r_par_typ;
    logic [PWIDTH-1:0]  r_prescale;
    logic [IW-1:0]      r_bit_idx;
    logic               r_tx_out;
    logic               r_busy;

    logic               w_timer_en;
    logic               w_bit_done;
    logic               w_par_bit;
    logic [IW-1:0]      w_next_idx;

    assign w_timer_en = (r_state != ST_IDLE);
    assign w_next_idx = r_bit_idx + IW'(1);

    always_comb begin
        w_par_bit = 1'b0;
        case (r_par_typ)
            PAR_EVEN: w_par_bit =  ^r_data;
            PAR_ODD:  w_par_bit = ~^r_data;
            default:  w_par_bit =  ^r_data;
        endcase
    end

    uart_tx_bit_timer #(
        .PWIDTH   (PWIDTH)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (w_timer_en),
        .prescale (r_prescale),
        .bit_done (w_bit_done)
    );

    // tx_out is loaded on each transition with the level of the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_prescale <= '0;
            r_bit_idx  <= '0;
            r_tx_out   <= LINE_IDLE;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx_out  <= LINE_IDLE;
                    r_busy    <= 1'b0;
                    r_bit_idx <= '0;
                    if (bus.tx_data_valid) begin
                        r_data     <= bus.tx_data_in;
                        r_par_en   <= bus.par_en;
                        r_par_typ  <= bus.par_typ;
                        r_prescale <= (bus.prescale == '0) ? PWIDTH'(1) : bus.prescale;
                        r_state    <= ST_START;
                        r_tx_out   <= START_BIT;
                        r_busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        r_tx_out  <= r_data[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == LAST_IDX) begin
                            if (r_par_en) begin
                                r_state  <= ST_PARITY;
                                r_tx_out <= w_par_bit;
                            end else begin
                                r_state  <= ST_STOP;
                                r_tx_out <= STOP_BIT;
                            end
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx_out  <= r_data[w_next_idx];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_state  <= ST_STOP;
                        r_tx_out <= STOP_BIT;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
                        r_state  <= ST_IDLE;
                        r_tx_out <= LINE_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx_out <= LINE_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_out = r_tx_out;
    assign bus.busy   = r_busy;

endmodule

`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer. The peer of the oversampled UART receiver path.
- Accepts a parallel data word with a valid strobe.
- Serialises it as start bit, DWIDTH data bits (LSB first), optional parity bit, and one stop bit.
- Each bit is held for `prescale` clk cycles, so TX and RX share the same clk and prescale setting. Sits between the host-side data source and the tx pin.

Parameters:
- DWIDTH, 8, data word width in bits.
- PWIDTH, 6, width of the prescale input. Legal prescale range is 1..2^PWIDTH-1.

Ports:
- clk  input  1  system clock (same oversampled clock used by the receiver)
- rst  input  1  asynchronous, active-low reset
- tx_data_in  input  DWIDTH  word to transmit
- tx_data_valid  input  1  request to transmit tx_data_in
- par_en  input  1  1 = insert parity bit
- par_typ  input  1  0 = even parity, 1 = odd parity
- prescale  input  PWIDTH  clk cycles per serial bit
- tx_out  output  1  serial line, idle high, registered
- busy  output  1  frame in progress, registered

Behaviour:
- Reset (rst low, asynchronous):
  - tx_out=1, busy=0, FSM=IDLE.
  - Bit timer, bit index and all latched fields clear to 0.
  - Reset mid-frame aborts the frame immediately. Line returns high with no partial stop bit.
- Accept:
  - Occurs in the cycle where FSM==IDLE and tx_data_valid==1.
  - Latches tx_data_in, par_en, par_typ and prescale. A latched prescale of 0 is treated as 1.
  - Inputs changing after accept have no effect on the current frame.
  - tx_data_valid while busy==1 is ignored, not queued.
- Latency: tx_out falls and busy rises on the clk edge after the accept cycle.
- FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> IDLE.
  - IDLE: tx_out=1, busy=0.
  - START: tx_out=0 for P cycles (P = latched prescale).
  - DATA: tx_out=data[i] for P cycles each, i=0..DWIDTH-1.
  - PARITY: tx_out = (^data) XOR par_typ for P cycles.
  - STOP: tx_out=1 for P cycles. Then IDLE, with busy=0 on the following edge.
- Bit timer:
  - Counts 0..P-1 and wraps to 0.
  - Each wrap advances the bit index or the FSM state.
  - Held at 0 in IDLE.
- Bit index:
  - Width clog2(DWIDTH).
  - Advances only in DATA.
  - Leaves DATA when index==DWIDTH-1 and the timer wraps.
- busy is high for exactly (2+DWIDTH+par_en)*P consecutive cycles per frame.
- Back-to-back frames:
  - Earliest next accept is the first cycle busy==0 (one IDLE cycle minimum).
  - tx_out stays 1 through that cycle.
- P=1: every state lasts one cycle. No state skipped.

Decomposition:
- Shared package uart_pkg:
  - TX state encoding (IDLE, START, DATA, PARITY, STOP).
  - Parity type constants PAR_EVEN=0, PAR_ODD=1.
  - Line level constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- One sub-module, uart_tx_bit_timer:
  - Counts clk cycles per bit against the latched prescale.
  - Outputs a one-cycle bit_done pulse.
  - Cleared when not enabled.
- The FSM, data/parity muxing and bit index remain in uart_tx_frame.

Test Plan:
1. Reset: hold rst=0 then release, no valid -> tx_out=1 and busy=0 continuously for 50 cycles.
2. Basic frame: tx_data_in=8'hA5, par_en=0, prescale=8, one-cycle valid.
   - Required tx_out sequence: 0 for 8 cycles, then 1,0,1,0,0,1,0,1 (8 cycles each), then 1 for 8 cycles.
   - busy high for exactly 80 cycles, starting the cycle after accept.
3. Parity on 8'hA5 (popcount 4) with par_en=1, prescale=8:
   - par_typ=0 -> parity bit 0.
   - par_typ=1 -> parity bit 1.
   - busy high for 88 cycles in both cases.
4. Parity on 8'h07 (popcount 3):
   - par_typ=0 -> parity bit 1.
   - par_typ=1 -> parity bit 0.
5. Input isolation:
   - During a frame of 8'h3C, pulse valid with 8'hFF and change prescale to 16 and par_en to 1.
   - Required: the frame completes as 8'h3C, P=8, no parity, and no second frame starts.
6. Reset mid-frame and minimum timing:
   - Assert rst in the 3rd data bit -> tx_out=1 and busy=0 asynchronously.
   - After release, send 8'h01 with prescale=1 -> 10 consecutive bits 0,1,0,0,0,0,0,0,0,1.
   - A second valid in the first busy==0 cycle starts the next frame on the following edge.
